// File: rtl/fir_ctrl_pkg.sv
// ============================================================================
//  Module      : fir_ctrl_pkg
//  Description : Shared types and defaults for the FIR stream arbiter:
//                FSM state enum, default parameters and channel-ID width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_ctrl_pkg;

   localparam int DEF_N_CH      = 4;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_FLUSH_LEN = 15;
   localparam int DEF_ID_DEPTH  = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARB   = 2'd1,
      S_XFER  = 2'd2,
      S_FLUSH = 2'd3
   } fir_arb_state_e;

   // Width of a channel index; never narrower than one bit.
   function automatic int chan_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [chan_id_w(DEF_N_CH)-1:0] chan_id_t;

endpackage

`default_nettype wire

// File: rtl/fir_id_fifo.sv
// ============================================================================
//  Module      : fir_id_fifo
//  Description : Small synchronous FIFO holding the channel ID of every
//                packet sent into the FIR, popped as result packets leave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_id_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head,
   output logic             o_underflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             r_underflow;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   // A push into a full FIFO is accepted only when a pop frees the slot.
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_underflow = r_underflow;

   // Storage array; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

   // Pointer update and sticky record of any pop attempted while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_underflow <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (i_pop && o_empty) r_underflow <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fir_stream_arbiter.sv
// ============================================================================
//  Module      : fir_stream_arbiter
//  Description : Packet-level round-robin arbiter sharing one FIR datapath
//                between N_CH AXI-stream sources, with result-ID tracking.
//                Build macro FIR_FLUSH_EN: when defined, FLUSH_LEN zero
//                samples are injected after every packet.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_stream_arbiter
   import fir_ctrl_pkg::*;
#(
   parameter int N_CH      = DEF_N_CH,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int FLUSH_LEN = DEF_FLUSH_LEN,
   parameter int ID_DEPTH  = DEF_ID_DEPTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_CH*DATA_W-1:0]      s_tdata,
   input  logic [N_CH-1:0]             s_tvalid,
   input  logic [N_CH-1:0]             s_tlast,
   output logic [N_CH-1:0]             s_tready,
   output logic [DATA_W-1:0]           fir_tdata,
   output logic                        fir_tvalid,
   output logic                        fir_tlast,
   input  logic                        fir_tready,
   input  logic                        res_tvalid,
   input  logic                        res_tready,
   input  logic                        res_tlast,
   output logic [chan_id_w(N_CH)-1:0]  res_tid,
   output logic                        res_tid_valid,
   output logic [N_CH-1:0]             grant,
   output logic                        busy
);

   localparam int CW = chan_id_w(N_CH);

   fir_arb_state_e   r_state;
   fir_arb_state_e   w_next;
   logic             r_rst_meta;
   logic             r_rst_n;
   logic [CW-1:0]    r_rr_ptr;
   logic [CW-1:0]    r_gnt_idx;
   logic [N_CH-1:0]  r_grant;
   logic [CW-1:0]    w_win_idx;
   logic             w_win_found;
   logic [CW-1:0]    w_next_ptr;
   logic             w_g_valid;
   logic             w_g_last;
   logic [DATA_W-1:0] w_g_data;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_id_underflow;
`ifdef FIR_FLUSH_EN
   localparam int FCW = $clog2(FLUSH_LEN + 1);
   logic [FCW-1:0]   r_flush_cnt;
   logic             w_flush_last;
   assign w_flush_last = (r_flush_cnt == FCW'(FLUSH_LEN - 1));
`endif

   // Reset asserts asynchronously and releases on a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rst_meta <= 1'b0;
         r_rst_n    <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_n    <= r_rst_meta;
      end
   end

   assign w_g_valid = s_tvalid[r_gnt_idx];
   assign w_g_last  = s_tlast[r_gnt_idx];
   assign w_g_data  = s_tdata[r_gnt_idx*DATA_W +: DATA_W];
   assign w_pop     = res_tvalid & res_tready & res_tlast;
   assign grant     = r_grant;
   assign busy      = (r_state == S_XFER) || (r_state == S_FLUSH);
   assign res_tid_valid = ~w_empty;
   assign w_next_ptr = (w_win_idx == CW'(N_CH - 1)) ? '0 : w_win_idx + 1'b1;

   // Round-robin search: first requester at or after r_rr_ptr, wrapping.
   always_comb begin
      w_win_found = 1'b0;
      w_win_idx   = '0;
      for (int i = 0; i < N_CH; i++) begin
         int j;
         j = int'(r_rr_ptr) + i;
         if (j >= N_CH) j = j - N_CH;
         if (!w_win_found && s_tvalid[j]) begin
            w_win_found = 1'b1;
            w_win_idx   = CW'(j);
         end
      end
   end

   // Next-state decode and the stream-side outputs of each state.
   always_comb begin
      w_next     = r_state;
      s_tready   = '0;
      fir_tdata  = '0;
      fir_tvalid = 1'b0;
      fir_tlast  = 1'b0;
      w_push     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((|s_tvalid) && !w_full) w_next = S_ARB;
         end
         S_ARB: begin
            if (!w_win_found) begin
               w_next = S_IDLE;
            end else if (!w_full) begin
               w_next = S_XFER;
               w_push = 1'b1;
            end
         end
         S_XFER: begin
            fir_tdata           = w_g_data;
            fir_tvalid          = w_g_valid;
            s_tready[r_gnt_idx] = fir_tready;
`ifdef FIR_FLUSH_EN
            if (w_g_valid && fir_tready && w_g_last) w_next = S_FLUSH;
`else
            fir_tlast = w_g_valid & w_g_last;
            if (w_g_valid && fir_tready && w_g_last) w_next = S_ARB;
`endif
         end
`ifdef FIR_FLUSH_EN
         S_FLUSH: begin
            fir_tvalid = 1'b1;
            fir_tlast  = w_flush_last;
            if (fir_tready && w_flush_last) w_next = S_ARB;
         end
`endif
         default: w_next = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge r_rst_n) begin
      if (!r_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Owner capture on a winning ARB cycle; owner released at packet end.
   always_ff @(posedge clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_rr_ptr  <= '0;
         r_gnt_idx <= '0;
         r_grant   <= '0;
      end else if (r_state == S_ARB && w_next == S_XFER) begin
         r_gnt_idx <= w_win_idx;
         r_grant   <= N_CH'(1) << w_win_idx;
         r_rr_ptr  <= w_next_ptr;
      end else if (busy && w_next == S_ARB) begin
         r_grant   <= '0;
      end
   end

`ifdef FIR_FLUSH_EN
   // Counts accepted zero beats; restarts for the next packet.
   always_ff @(posedge clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_flush_cnt <= '0;
      end else if (r_state == S_FLUSH && fir_tready) begin
         r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + 1'b1;
      end
   end
`endif

   fir_id_fifo #(
      .WIDTH (CW),
      .DEPTH (ID_DEPTH)
   ) u_id_fifo (
      .clk         (clk),
      .rst_n       (r_rst_n),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_data      (w_win_idx),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (res_tid),
      .o_underflow (w_id_underflow)
   );

endmodule

`default_nettype wire

// File: tb/tb_fir_stream_arbiter.sv
// ============================================================================
//  Module      : tb_fir_stream_arbiter
//  Description : Randomized self-checking bench for fir_stream_arbiter with
//                a packet-level reference model (round-robin order, expected
//                FIR stream, owner-ID sequence). Honours FIR_FLUSH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_stream_arbiter;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int FL  = 15;
   localparam int DEP = 4;
`ifdef FIR_FLUSH_EN
   localparam int FLUSH_ON = 1;
`else
   localparam int FLUSH_ON = 0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N*DW-1:0] s_tdata;
   logic [N-1:0]    s_tvalid, s_tlast, s_tready;
   logic [DW-1:0]   fir_tdata;
   logic            fir_tvalid, fir_tlast, fir_tready;
   logic            res_tvalid, res_tready, res_tlast;
   logic [1:0]      res_tid;
   logic            res_tid_valid;
   logic [N-1:0]    grant;
   logic            busy;

   always #5 clk = ~clk;

   fir_stream_arbiter #(.N_CH(N), .DATA_W(DW), .FLUSH_LEN(FL), .ID_DEPTH(DEP)) dut (
      .clk(clk), .reset(reset),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .fir_tdata(fir_tdata), .fir_tvalid(fir_tvalid), .fir_tlast(fir_tlast),
      .fir_tready(fir_tready),
      .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tlast(res_tlast),
      .res_tid(res_tid), .res_tid_valid(res_tid_valid),
      .grant(grant), .busy(busy)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [DW:0] src_q [N][$];
   logic [DW:0] mdl_q [N][$];
   logic [DW:0] obs_beats [$];
   int          obs_cyc   [$];
   int          obs_grant [$];
   int          obs_tid   [$];
   logic [DW:0] exp_beats [$];
   int          exp_order [$];
   int          mdl_ptr = 0;
   bit          tready_toggle = 1'b0;
   bit          pop_req = 1'b0;
   logic [N-1:0] prev_grant = '0;
   logic [N-1:0] last_grant;
   logic         last_busy;

   function automatic int onehot_idx(input logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return -1;
   endfunction

   task automatic clear_logs();
      obs_beats.delete(); obs_cyc.delete(); obs_grant.delete();
      obs_tid.delete(); exp_beats.delete(); exp_order.delete();
   endtask

   // Queue a packet; fixed >= 0 gives data fixed, fixed+1, ...
   task automatic add_packet(input int ch, input int len, input int fixed);
      for (int b = 0; b < len; b++) begin
         logic [DW:0] beat;
         beat[DW-1:0] = (fixed >= 0) ? DW'(fixed + b) : DW'($urandom);
         beat[DW]     = (b == len - 1);
         src_q[ch].push_back(beat);
         mdl_q[ch].push_back(beat);
      end
   endtask

   // Packet-level model: round-robin service order and resulting FIR stream.
   task automatic build_expected();
      int cnt [N];
      int left;
      left = 0;
      for (int k = 0; k < N; k++) begin
         cnt[k] = 0;
         foreach (mdl_q[k][i]) if (mdl_q[k][i][DW]) cnt[k]++;
         left += cnt[k];
      end
      while (left > 0) begin
         int w;
         w = -1;
         for (int i = 0; i < N; i++) begin
            int j;
            j = (mdl_ptr + i) % N;
            if (w < 0 && cnt[j] > 0) w = j;
         end
         exp_order.push_back(w);
         cnt[w]--; left--;
         mdl_ptr = (w + 1) % N;
         forever begin
            logic [DW:0] b;
            b = mdl_q[w].pop_front();
            if (b[DW]) begin
               if (FLUSH_ON != 0) begin
                  b[DW] = 1'b0;
                  exp_beats.push_back(b);
                  for (int z = 0; z < FL; z++) exp_beats.push_back({(z == FL - 1), {DW{1'b0}}});
               end else begin
                  exp_beats.push_back(b);
               end
               break;
            end
            exp_beats.push_back(b);
         end
      end
   endtask

   // One clock: drive at negedge, sample just before the posedge.
   task automatic step();
      logic [N-1:0] acc;
      for (int k = 0; k < N; k++) begin
         if (src_q[k].size() > 0) begin
            s_tvalid[k] = 1'b1;
            s_tlast[k]  = src_q[k][0][DW];
            s_tdata[k*DW +: DW] = src_q[k][0][DW-1:0];
         end else begin
            s_tvalid[k] = 1'b0;
            s_tlast[k]  = 1'b0;
            s_tdata[k*DW +: DW] = '0;
         end
      end
      fir_tready = tready_toggle ? (cyc % 2 == 0) : 1'b1;
      res_tvalid = pop_req; res_tready = pop_req; res_tlast = pop_req;
      #4;
      total++;
      if ((s_tready & ~grant) !== '0) begin
         bad++;
         $display("FAIL tready_excl: s_tready=%b grant=%b required no ungranted ready", s_tready, grant);
      end
      total++;
      if (busy !== (grant != '0)) begin
         bad++;
         $display("FAIL busy_vs_grant: busy=%b grant=%b", busy, grant);
      end
      if (fir_tvalid && fir_tready) begin
         obs_beats.push_back({fir_tlast, fir_tdata});
         obs_cyc.push_back(cyc);
      end
      if (grant != '0 && grant != prev_grant) obs_grant.push_back(onehot_idx(grant));
      prev_grant = grant;
      if (pop_req && res_tid_valid) obs_tid.push_back(int'(res_tid));
      last_grant = grant;
      last_busy  = busy;
      acc = s_tvalid & s_tready;
      @(negedge clk);
      for (int k = 0; k < N; k++) if (acc[k]) void'(src_q[k].pop_front());
      cyc++;
   endtask

   task automatic run_until(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (obs_beats.size() < n && k < budget) begin step(); k++; end
      if (obs_beats.size() < n) begin
         total++; bad++;
         $display("FAIL %s_timeout: beats=%0d required=%0d", tag, obs_beats.size(), n);
      end
      repeat (4) step();
   endtask

   task automatic compare_stream(input string tag);
      total++;
      if (obs_beats.size() != exp_beats.size()) begin
         bad++;
         $display("FAIL %s_len: got %0d beats expected %0d", tag, obs_beats.size(), exp_beats.size());
      end
      for (int i = 0; i < obs_beats.size() && i < exp_beats.size(); i++) begin
         total++;
         if (obs_beats[i] !== exp_beats[i]) begin
            bad++;
            $display("FAIL %s_beat%0d: got last=%b data=%h expected last=%b data=%h", tag, i,
                     obs_beats[i][DW], obs_beats[i][DW-1:0], exp_beats[i][DW], exp_beats[i][DW-1:0]);
         end
      end
   endtask

   task automatic compare_order(input string tag, input int q [$]);
      total++;
      if (q.size() != exp_order.size()) begin
         bad++;
         $display("FAIL %s_count: got %0d expected %0d", tag, q.size(), exp_order.size());
      end
      for (int i = 0; i < q.size() && i < exp_order.size(); i++) begin
         total++;
         if (q[i] != exp_order[i]) begin
            bad++;
            $display("FAIL %s%0d: got ch%0d expected ch%0d", tag, i, q[i], exp_order[i]);
         end
      end
   endtask

   task automatic drain();
      pop_req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (!res_tid_valid) break;
         step();
      end
      pop_req = 1'b0;
      step();
   endtask

   task automatic test_reset();
      s_tvalid = '1; s_tlast = '0; s_tdata = '1;
      fir_tready = 1'b1; res_tvalid = 1'b0; res_tready = 1'b0; res_tlast = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (s_tready !== '0)    begin bad++; $display("FAIL rst_s_tready: got %b expected 0", s_tready); end
      total++; if (fir_tvalid !== 1'b0) begin bad++; $display("FAIL rst_fir_tvalid: got %b expected 0", fir_tvalid); end
      total++; if (fir_tdata !== '0)   begin bad++; $display("FAIL rst_fir_tdata: got %h expected 0", fir_tdata); end
      total++; if (fir_tlast !== 1'b0)  begin bad++; $display("FAIL rst_fir_tlast: got %b expected 0", fir_tlast); end
      total++; if (grant !== '0)       begin bad++; $display("FAIL rst_grant: got %b expected 0", grant); end
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
      total++; if (res_tid_valid !== 1'b0 || res_tid !== '0) begin
         bad++; $display("FAIL rst_res_tid: got v=%b id=%0d expected 0/0", res_tid_valid, res_tid);
      end
      reset = 1'b1;
      repeat (4) step();
      clear_logs();
   endtask

   task automatic test_single();
      int start;
      clear_logs();
      add_packet(0, 4, 1);
      build_expected();
      start = cyc;
      step();
      total++; if (last_grant !== 4'b0000) begin bad++; $display("FAIL single_grant_c0: got %b expected 0000", last_grant); end
      step();
      total++; if (last_grant !== 4'b0000) begin bad++; $display("FAIL single_grant_c1: got %b expected 0000", last_grant); end
      step();
      total++; if (last_grant !== 4'b0001) begin bad++; $display("FAIL single_grant_c2: got %b expected 0001", last_grant); end
      total++;
      if (obs_cyc.size() == 0 || obs_cyc[0] != start + 2) begin
         bad++; $display("FAIL single_latency: first beat cycle offset %0d expected 2",
                         (obs_cyc.size() > 0) ? obs_cyc[0] - start : -1);
      end
      run_until(exp_beats.size(), 100, "single");
      compare_stream("single");
      drain();
      compare_order("single_tid", obs_tid);
   endtask

   task automatic test_round_robin();
      int ends [$];
      clear_logs();
      pop_req = 1'b1;
      for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) add_packet(k, 2, -1);
      build_expected();
      run_until(exp_beats.size(), 600, "rr");
      compare_stream("rr");
      compare_order("rr_grant", obs_grant);
      compare_order("rr_tid", obs_tid);
      foreach (exp_beats[i]) if (exp_beats[i][DW]) ends.push_back(i);
      for (int p = 0; p + 1 < ends.size(); p++) begin
         if (ends[p] + 1 < obs_cyc.size()) begin
            total++;
            if (obs_cyc[ends[p] + 1] - obs_cyc[ends[p]] != 2) begin
               bad++; $display("FAIL rr_bubble%0d: gap %0d cycles expected 2", p,
                               obs_cyc[ends[p] + 1] - obs_cyc[ends[p]]);
            end
         end
      end
      pop_req = 1'b0;
      drain();
   endtask

   task automatic test_backpressure();
      clear_logs();
      tready_toggle = 1'b1;
      pop_req = 1'b1;
      add_packet(2, 5, -1);
      add_packet(3, 3, -1);
      add_packet(1, 1, -1);
      build_expected();
      run_until(exp_beats.size(), 800, "bp");
      compare_stream("bp");
      compare_order("bp_tid", obs_tid);
      tready_toggle = 1'b0;
      pop_req = 1'b0;
      drain();
   endtask

   task automatic test_tlast();
      clear_logs();
      pop_req = 1'b1;
      add_packet(1, 3, -1);
      add_packet(2, 2, -1);
      build_expected();
      run_until(exp_beats.size(), 300, "tlast");
      total++;
      if (obs_beats.size() < 3 || obs_beats[2][DW] !== ((FLUSH_ON != 0) ? 1'b0 : 1'b1)) begin
         bad++; $display("FAIL tlast_beat3: got %b expected %0d",
                         (obs_beats.size() >= 3) ? obs_beats[2][DW] : 1'bx, (FLUSH_ON != 0) ? 0 : 1);
      end
      compare_stream("tlast");
      compare_order("tlast_grant", obs_grant);
      pop_req = 1'b0;
      drain();
   endtask

   task automatic test_fifo_full();
      int per;
      clear_logs();
      per = 1 + FLUSH_ON * FL;
      add_packet(0, 1, -1); add_packet(1, 1, -1); add_packet(2, 1, -1);
      add_packet(3, 1, -1); add_packet(0, 1, -1);
      build_expected();
      run_until(4 * per, 400, "full");
      repeat (30) step();
      total++;
      if (obs_beats.size() != 4 * per) begin
         bad++; $display("FAIL full_stall_beats: got %0d expected %0d", obs_beats.size(), 4 * per);
      end
      total++;
      if (last_grant !== '0 || last_busy !== 1'b0) begin
         bad++; $display("FAIL full_stall_idle: grant=%b busy=%b expected 0/0", last_grant, last_busy);
      end
      total++;
      if (res_tid_valid !== 1'b1 || int'(res_tid) != exp_order[0]) begin
         bad++; $display("FAIL full_head: v=%b id=%0d expected 1/%0d", res_tid_valid, res_tid, exp_order[0]);
      end
      pop_req = 1'b1;
      step();
      pop_req = 1'b0;
      run_until(exp_beats.size(), 100, "full_resume");
      compare_stream("full");
      compare_order("full_grant", obs_grant);
      drain();
      compare_order("full_tid", obs_tid);
   endtask

   task automatic test_reset_mid();
      clear_logs();
      add_packet(2, 6, -1);
      run_until(2, 40, "rmid");
      reset = 1'b0;
      #1;
      total++;
      if (fir_tvalid !== 1'b0 || s_tready !== '0 || grant !== '0 || busy !== 1'b0 || res_tid_valid !== 1'b0) begin
         bad++; $display("FAIL rmid_outputs: tvalid=%b tready=%b grant=%b busy=%b idv=%b expected all 0",
                         fir_tvalid, s_tready, grant, busy, res_tid_valid);
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) begin src_q[k].delete(); mdl_q[k].delete(); end
      repeat (2) step();
      reset = 1'b1;
      repeat (4) step();
      clear_logs();
      mdl_ptr = 0;
      pop_req = 1'b1;
      add_packet(3, 2, -1);
      add_packet(0, 2, -1);
      build_expected();
      run_until(exp_beats.size(), 200, "rmid_after");
      total++;
      if (obs_grant.size() == 0 || obs_grant[0] != 0) begin
         bad++; $display("FAIL rmid_restart: first grant ch%0d expected ch0",
                         (obs_grant.size() > 0) ? obs_grant[0] : -1);
      end
      compare_stream("rmid");
      pop_req = 1'b0;
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_tlast();
      test_fifo_full();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fir_stream_arbiter.md
# fir_stream_arbiter

- Packet-level round-robin arbiter that shares the single 15-tap FIR datapath between `N_CH` AXI-stream sample sources.
- Grants one source for a whole packet, delimited by `tlast`, and forwards that packet's samples to the FIR slave port.
- Optionally injects zero samples after each packet so filter history never leaks between channels.
- Tracks which channel owns each FIR result packet and presents its ID to the output-side consumer.

## Interface
Parameters:
- `N_CH`, 4: number of requesting channels, 2..8.
- `DATA_W`, 16: sample width, signed.
- `FLUSH_LEN`, 15: zero samples injected after each packet (equals tap count).
- `ID_DEPTH`, 4: depth of the result-ID FIFO, power of 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_tdata`  in  `N_CH*DATA_W`  channel samples; channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `s_tvalid`  in  `N_CH`  per-channel valid.
- `s_tlast`  in  `N_CH`  per-channel end of packet.
- `s_tready`  out  `N_CH`  per-channel ready; only the granted bit can be high.
- `fir_tdata`  out  `DATA_W`  sample to the FIR.
- `fir_tvalid`  out  1  sample to the FIR is valid.
- `fir_tlast`  out  1  last beat of the forwarded packet, including flush beats.
- `fir_tready`  in  1  FIR accepts a sample.
- `res_tvalid`, `res_tready`, `res_tlast`  in  1 each  observed FIR result-side handshake; the arbiter never drives these.
- `res_tid`  out  `$clog2(N_CH)`  channel owning the current result packet (ID FIFO head).
- `res_tid_valid`  out  1  ID FIFO not empty.
- `grant`  out  `N_CH`  one-hot current owner; 0 when none.
- `busy`  out  1  high in XFER or FLUSH.

## Operation
FSM states:
- IDLE: no owner. Enter ARB when any `s_tvalid` is set and the ID FIFO is not full.
- ARB: registered decision in one cycle.
  - Pick the first requesting channel at or after `rr_ptr` (wrapping).
  - Set `grant`, push the channel ID into the ID FIFO, set `rr_ptr` to winner+1 mod `N_CH`, go to XFER.
  - If no request remains, return to IDLE.
- XFER: combinational mux of the granted channel.
  - `fir_tdata`/`fir_tvalid` come from that channel; `s_tready[g] = fir_tready`.
  - A beat completes when `s_tvalid[g] & fir_tready`.
  - A beat with `s_tlast[g]` high goes to FLUSH when flush is compiled in; otherwise `fir_tlast` carries that beat and the FSM goes to ARB.
- FLUSH: drive `fir_tdata = 0`, `fir_tvalid = 1`, all `s_tready` low.
  - Count accepted beats 0..`FLUSH_LEN-1`; `fir_tlast` is high on the final flush beat.
  - After that beat go to ARB. `grant` holds the owner through FLUSH.

ID FIFO:
- Pop on `res_tvalid & res_tready & res_tlast`.
- A push and a pop in the same cycle keep the occupancy unchanged.
- A pop while empty is ignored and leaves the sticky `id_underflow` debug flop set.

Rules:
- Non-granted `s_tready` are always 0.
- A packet is never preempted; a channel holding `s_tvalid` without `s_tlast` keeps the FIR indefinitely.
- With the FIFO full, ARB/IDLE stall. The active packet is unaffected.

## Timing
- Reset (async assert, sync deassert internally): FSM IDLE, `rr_ptr` 0, FIFO empty, flush counter 0.
  - Outputs reset to: `s_tready` 0, `fir_tdata` 0, `fir_tvalid` 0, `fir_tlast` 0, `res_tid` 0, `res_tid_valid` 0, `grant` 0, `busy` 0.
- Reset mid-packet aborts the transfer without completing the packet; the FIFO contents are discarded.
- Request-to-first-beat latency: 2 cycles (IDLE→ARB→XFER); the data path in XFER has 0 cycles latency.
- Back-to-back packets have one ARB bubble cycle between them.
- Flush cost: exactly `FLUSH_LEN` accepted beats; stalls extend it cycle-for-cycle.
- `res_tid` updates the cycle after a pop or after a push into an empty FIFO.

## Configuration
- `FIR_FLUSH_EN` defined: the FLUSH state and counter are built.
  - Every packet is followed by `FLUSH_LEN` zero beats, and `fir_tlast` marks the last flush beat.
- Not defined: the FLUSH state is absent.
  - `fir_tlast` equals the source `s_tlast` on the final data beat, and filter history carries across channels.

## Structure
- `fir_ctrl_pkg` holds:
  - the `fir_arb_state_e` enum (IDLE, ARB, XFER, FLUSH);
  - default constants for `N_CH`, `DATA_W`, `FLUSH_LEN`, `ID_DEPTH`;
  - the `chan_id_t` width function.
- Sub-module `fir_id_fifo`: synchronous FIFO with push, pop, full, empty and head, reset to empty. The arbiter FSM and round-robin logic stay in the top module.

## Test plan
- Single channel, `s_tvalid[0]` held high, 4-beat packet 1,2,3,4 with `tlast` on 4 → `grant=0001` two cycles after request; FIR sees 1,2,3,4 then 15 zeros; `fir_tlast` only on the 15th zero (flush build).
- All 4 channels requesting 2-beat packets continuously → grant order 0,1,2,3,0; exactly one ARB bubble between packets; `res_tid` sequence 0,1,2,3.
- `fir_tready` toggling 1/0 each cycle during XFER and FLUSH → no sample lost or duplicated; flush still totals 15 accepted zeros.
- 5 packets granted with no `res_tlast` pops (`ID_DEPTH=4`) → the 5th grant is withheld until one `res_tvalid & res_tready & res_tlast` pop; a simultaneous push and pop keeps the count at 4.
- `reset` asserted low at beat 2 of a 6-beat packet → all outputs 0 immediately; after release the next grant restarts from channel 0.
- Built without `FIR_FLUSH_EN`, 3-beat packet → `fir_tlast` on beat 3; the next channel is granted on the following ARB cycle with no zero beats.
